// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: AXI constants, FSM encodings and line-address helper shared
// by the cache-to-AXI bridge and its write-back engine.
package cache_axi_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      R_IDLE,
      R_AR,
      R_DATA
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_AW,
      W_DATA,
      W_RESP
   } wr_state_t;

   // Line number of a byte address: drops the in-line offset bits.
   function automatic logic [31:0] line_addr(input logic [31:0] addr,
                                             input int unsigned offset_bits);
      return addr >> offset_bits;
   endfunction

endpackage

// File: rtl/cache_axi_wr_engine.sv
// cache_axi_wr_engine: single-entry write-back line buffer that replays one
// victim line as an AXI4 INCR burst (AW, WORDS_PER_LINE W beats, B).
module cache_axi_wr_engine
   import cache_axi_pkg::*;
#(
   parameter int BYTES_PER_LINE = 16,
   parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
   parameter int ID_WIDTH       = 4,
   parameter int WR_ID          = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_req,
   input  logic [31:0]                 wr_addr,
   input  logic [BYTES_PER_LINE*8-1:0] wr_data,
   output logic                        wr_rdy,
   output logic [31:0]                 pend_addr,
   output logic [ID_WIDTH-1:0]         awid,
   output logic [31:0]                 awaddr,
   output logic [7:0]                  awlen,
   output logic [2:0]                  awsize,
   output logic [1:0]                  awburst,
   output logic                        awvalid,
   input  logic                        awready,
   output logic [31:0]                 wdata,
   output logic [3:0]                  wstrb,
   output logic                        wlast,
   output logic                        wvalid,
   input  logic                        wready,
   input  logic                        bvalid,
   output logic                        bready
);

   localparam int unsigned OFFSET_BITS = $clog2(BYTES_PER_LINE);
   localparam int unsigned BEAT_W      = $clog2(WORDS_PER_LINE);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
   localparam logic [31:0] OFFSET_MASK = 32'(BYTES_PER_LINE - 1);

   wr_state_t                   state;
   wr_state_t                   state_next;
   logic [BEAT_W-1:0]           beat;
   logic [31:0]                 addr_q;
   logic [BYTES_PER_LINE*8-1:0] line_q;
   logic                        accept;

   assign accept = (state == W_IDLE) && wr_req;

   // State register, beat counter and line-aligned address capture.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= W_IDLE;
         beat   <= '0;
         addr_q <= '0;
      end else begin
         state <= state_next;
         if (accept)
            addr_q <= wr_addr & ~OFFSET_MASK;
         if (state == W_AW && awready)
            beat <= '0;
         else if (wvalid && wready && beat != LAST_BEAT)
            beat <= beat + 1'b1;
      end
   end

   // Victim line capture.
   // NOTE: the line buffer is data-only and is never read before it is
   // loaded, so it has no reset and stays a plain register bank.
   always_ff @(posedge clk) begin
      if (accept)
         line_q <= wr_data;
   end

   // Next-state and channel handshake decode.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      wr_rdy     = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wlast      = 1'b0;
      bready     = 1'b0;
      case (state)
         W_IDLE: begin
            wr_rdy = 1'b1;
            if (wr_req)
               state_next = W_AW;
         end
         W_AW: begin
            awvalid = 1'b1;
            if (awready)
               state_next = W_DATA;
         end
         W_DATA: begin
            wvalid = 1'b1;
            wlast  = (beat == LAST_BEAT);
            if (wready && beat == LAST_BEAT)
               state_next = W_RESP;
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid)
               state_next = W_IDLE;
         end
         default: state_next = W_IDLE;
      endcase
   end

   assign wdata     = line_q[32*int'(beat) +: 32];
   assign wstrb     = 4'hF;
   assign awaddr    = addr_q;
   assign pend_addr = addr_q;
   assign awid      = ID_WIDTH'(WR_ID);
   assign awlen     = 8'(WORDS_PER_LINE - 1);
   assign awsize    = SIZE_4B;
   assign awburst   = BURST_INCR;

   // The cache must not issue a write-back while the buffer is occupied.
   a_wr_req_when_busy: assert property (@(posedge clk) disable iff (reset)
      wr_req |-> wr_rdy);

endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: converts L1 line refills and write-backs into AXI4 INCR
// bursts. The read engine and RAW hazard check live here; the write-back
// engine is cache_axi_wr_engine.
// Build option CACHE_AXI_BRIDGE_RAW_CHECK_EN: when defined, only a refill to
// the same line as a pending/incoming write-back waits; otherwise every
// refill waits for the write-back to complete.
module cache_axi_bridge
   import cache_axi_pkg::*;
#(
   parameter int BYTES_PER_LINE = 16,
   parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
   parameter int ID_WIDTH       = 4,
   parameter int RD_ID          = 0,
   parameter int WR_ID          = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   // cache refill
   input  logic                        rd_req,
   input  logic [31:0]                 rd_addr,
   output logic                        rd_rdy,
   output logic                        ret_valid,
   output logic                        ret_last,
   output logic [31:0]                 ret_data,
   // cache write-back
   input  logic                        wr_req,
   input  logic [31:0]                 wr_addr,
   input  logic [BYTES_PER_LINE*8-1:0] wr_data,
   output logic                        wr_rdy,
   // AXI AR
   output logic [ID_WIDTH-1:0]         arid,
   output logic [31:0]                 araddr,
   output logic [7:0]                  arlen,
   output logic [2:0]                  arsize,
   output logic [1:0]                  arburst,
   output logic                        arvalid,
   input  logic                        arready,
   // AXI R
   input  logic [ID_WIDTH-1:0]         rid,
   input  logic [31:0]                 rdata,
   input  logic [1:0]                  rresp,
   input  logic                        rlast,
   input  logic                        rvalid,
   output logic                        rready,
   // AXI AW
   output logic [ID_WIDTH-1:0]         awid,
   output logic [31:0]                 awaddr,
   output logic [7:0]                  awlen,
   output logic [2:0]                  awsize,
   output logic [1:0]                  awburst,
   output logic                        awvalid,
   input  logic                        awready,
   // AXI W
   output logic [31:0]                 wdata,
   output logic [3:0]                  wstrb,
   output logic                        wlast,
   output logic                        wvalid,
   input  logic                        wready,
   // AXI B
   input  logic [ID_WIDTH-1:0]         bid,
   input  logic [1:0]                  bresp,
   input  logic                        bvalid,
   output logic                        bready
);

   localparam int unsigned OFFSET_BITS = $clog2(BYTES_PER_LINE);

   rd_state_t   rstate;
   rd_state_t   rstate_next;
   logic [31:0] raddr_q;
   logic [31:0] wr_pend_addr;
   logic        raw_block;
   logic        unused_resp;

   // Response codes and IDs carry no information the cache can act on.
   assign unused_resp = (rresp == RESP_OKAY) ^ (bresp == RESP_OKAY) ^ (^rid) ^ (^bid);

   cache_axi_wr_engine #(
      .BYTES_PER_LINE(BYTES_PER_LINE),
      .WORDS_PER_LINE(WORDS_PER_LINE),
      .ID_WIDTH      (ID_WIDTH),
      .WR_ID         (WR_ID)
   ) u_wr_engine (
      .clk      (clk),
      .reset    (reset),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_rdy   (wr_rdy),
      .pend_addr(wr_pend_addr),
      .awid     (awid),
      .awaddr   (awaddr),
      .awlen    (awlen),
      .awsize   (awsize),
      .awburst  (awburst),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wlast    (wlast),
      .wvalid   (wvalid),
      .wready   (wready),
      .bvalid   (bvalid),
      .bready   (bready)
   );

`ifdef CACHE_AXI_BRIDGE_RAW_CHECK_EN
   // Hold a refill only when it targets the line being written back, whether
   // already buffered or arriving this very cycle.
   assign raw_block =
      (~wr_rdy & (line_addr(rd_addr, OFFSET_BITS) == line_addr(wr_pend_addr, OFFSET_BITS))) |
      (wr_req  & (line_addr(rd_addr, OFFSET_BITS) == line_addr(wr_addr, OFFSET_BITS)));
`else
   logic unused_pend;
   assign unused_pend = ^wr_pend_addr;
   // Any write-back in flight (or starting now) holds off every refill.
   assign raw_block = ~wr_rdy | wr_req;
`endif

   // Read state register and refill address capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rstate  <= R_IDLE;
         raddr_q <= '0;
      end else begin
         rstate <= rstate_next;
         if (rstate == R_IDLE && rd_req && !raw_block)
            raddr_q <= rd_addr;
      end
   end

   // Read next-state and AR/R handshake decode.
   always_comb begin
      rstate_next = rstate;
      rd_rdy      = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      case (rstate)
         R_IDLE: begin
            rd_rdy = ~raw_block;
            if (rd_req && !raw_block)
               rstate_next = R_AR;
         end
         R_AR: begin
            arvalid = 1'b1;
            if (arready)
               rstate_next = R_DATA;
         end
         R_DATA: begin
            rready = 1'b1;
            if (rvalid && rlast)
               rstate_next = R_IDLE;
         end
         default: rstate_next = R_IDLE;
      endcase
   end

   assign arid      = ID_WIDTH'(RD_ID);
   assign araddr    = raddr_q;
   assign arlen     = 8'(WORDS_PER_LINE - 1);
   assign arsize    = SIZE_4B;
   assign arburst   = BURST_INCR;

   assign ret_valid = rvalid & rready;
   assign ret_last  = rlast;
   assign ret_data  = rdata;

endmodule
